// File: rtl/multi_debounce.sv
// multi_debounce: parametrised multi-channel switch debouncer.
//
// Each raw switch input is optionally passed through a two-flop synchroniser.
// It is then qualified against the shared millisecond strobe m_tick. A level that
// differs from the current debounced level is accepted only after it has
// persisted for STABLE_TICKS consecutive ticks. Any cycle where the sample
// matches the debounced level again discards the progress made so far.
// Accepted changes produce one-cycle rise/fall pulses on the same edge that
// db_level changes.
//
// Optional feature macro: MULTI_DEBOUNCE_SYNC_EN
//   defined   - two-flop synchroniser per channel, reset to 0 (+2 cycles latency);
//               required when sw comes straight from board pins.
//   undefined - sw is used directly; only for inputs already synchronous to clk.
//
// Parameters:
//   CHANNELS     - number of independent switch channels (>= 1)
//   STABLE_TICKS - consecutive m_tick pulses a new level must persist (1..255)
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous, active-high reset
//   sw         - raw switch levels, one per channel
//   m_tick     - one-clk strobe from the shared tick generator
//   db_level   - debounced level (registered)
//   rise_pulse - one-cycle pulse on an accepted 0->1 change (registered)
//   fall_pulse - one-cycle pulse on an accepted 1->0 change (registered)

module multi_debounce #(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned STABLE_TICKS = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] sw,
  input  logic                m_tick,
  output logic [CHANNELS-1:0] db_level,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse
);

  localparam int unsigned CntW = $clog2(STABLE_TICKS + 1);
  // Terminal count: the tick seen at this count is the STABLE_TICKS-th one.
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_TICKS - 1);

  logic [CHANNELS-1:0] s;

`ifdef MULTI_DEBOUNCE_SYNC_EN
  logic [CHANNELS-1:0] sync1_q;
  logic [CHANNELS-1:0] sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  assign s = sw;
`endif

  logic [CHANNELS-1:0]           level_q, level_d;
  logic [CHANNELS-1:0]           rise_q, rise_d;
  logic [CHANNELS-1:0]           fall_q, fall_d;
  logic [CHANNELS-1:0][CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (s[i] == level_q[i]) begin
        // Back at the current level: any partial qualification is discarded.
        cnt_d[i] = '0;
      end else if (m_tick) begin
        if (cnt_q[i] == CntMax) begin
          level_d[i] = s[i];
          cnt_d[i]   = '0;
          rise_d[i]  = s[i];
          fall_d[i]  = ~s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign db_level   = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

endmodule

// File: tb/tb_multi_debounce.sv
module tb_multi_debounce;
  localparam int unsigned CH = 4;
  localparam int unsigned ST = 3;
`ifdef MULTI_DEBOUNCE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CH-1:0] sw = '0;
  logic          m_tick = 1'b0;
  logic [CH-1:0] db_level, rise_pulse, fall_pulse;

  multi_debounce #(
    .CHANNELS    (CH),
    .STABLE_TICKS(ST)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sw        (sw),
    .m_tick    (m_tick),
    .db_level  (db_level),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: counts ticks seen while the sample disagrees with the level.
  logic [CH-1:0] m_level = '0, m_rise = '0, m_fall = '0;
  int            m_run [CH];
  logic [CH-1:0] m_hist [$];  // sw values still travelling through the synchroniser

  typedef struct {
    logic [CH-1:0] sw_v;
    int            period;
    logic [CH-1:0] exp_rise;
    logic [CH-1:0] exp_fall;
  } entry_t;

  entry_t tbl [7];

  task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus, advance the model, compare after the edge.
  task automatic step(input logic [CH-1:0] sw_v, input logic tick_v, input logic rst_v);
    logic [CH-1:0] s;
    sw     = sw_v;
    m_tick = tick_v;
    reset  = rst_v;
    if (LAT == 0) s = sw_v;
    else          s = m_hist[0];
    m_rise = '0;
    m_fall = '0;
    if (rst_v) begin
      m_level = '0;
      foreach (m_run[i]) m_run[i] = 0;
      m_hist.delete();
      repeat (LAT) m_hist.push_back('0);
    end else begin
      for (int i = 0; i < int'(CH); i++) begin
        if (s[i] == m_level[i]) m_run[i] = 0;
        else if (tick_v) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == int'(ST)) begin
            m_level[i] = s[i];
            m_rise[i]  = s[i];
            m_fall[i]  = ~s[i];
            m_run[i]   = 0;
          end
        end
      end
      m_hist.push_back(sw_v);
      if (m_hist.size() > LAT) void'(m_hist.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
    check("db_level", db_level, m_level);
    check("rise_pulse", rise_pulse, m_rise);
    check("fall_pulse", fall_pulse, m_fall);
  endtask

  // Apply one table entry: hold sw_v with a periodic tick and find the first pulse.
  task automatic run_entry(input int idx);
    entry_t        e;
    int            seen, exp_k, first;
    logic [CH-1:0] got_r, got_f;
    e     = tbl[idx];
    seen  = 0;
    exp_k = -1;
    for (int k = 0; k < 200 && exp_k < 0; k++) begin
      if (k >= LAT && (k % e.period) == 0) begin
        seen++;
        if (seen == int'(ST)) exp_k = k;
      end
    end
    first = -1;
    got_r = '0;
    got_f = '0;
    for (int k = 0; k <= exp_k + 2; k++) begin
      step(e.sw_v, (k % e.period) == 0, 1'b0);
      if (first < 0 && (rise_pulse | fall_pulse) != '0) begin
        first = k;
        got_r = rise_pulse;
        got_f = fall_pulse;
      end
    end
    check_int($sformatf("entry%0d latency", idx), first, exp_k);
    check($sformatf("entry%0d rise", idx), got_r, e.exp_rise);
    check($sformatf("entry%0d fall", idx), got_f, e.exp_fall);
    repeat (3) step(e.sw_v, 1'b0, 1'b0);
  endtask

  initial begin
    int            pulses;
    logic [CH-1:0] sw_r;
    logic          tick_hi;

    foreach (m_run[i]) m_run[i] = 0;
    tbl[0] = '{sw_v: 4'b0001, period: 4, exp_rise: 4'b0001, exp_fall: 4'b0000};
    tbl[1] = '{sw_v: 4'b1101, period: 1, exp_rise: 4'b1100, exp_fall: 4'b0000};
    tbl[2] = '{sw_v: 4'b0001, period: 4, exp_rise: 4'b0000, exp_fall: 4'b1100};
    tbl[3] = '{sw_v: 4'b0110, period: 2, exp_rise: 4'b0110, exp_fall: 4'b0001};
    tbl[4] = '{sw_v: 4'b1001, period: 3, exp_rise: 4'b1001, exp_fall: 4'b0110};
    tbl[5] = '{sw_v: 4'b1111, period: 1, exp_rise: 4'b0110, exp_fall: 4'b0000};
    tbl[6] = '{sw_v: 4'b0000, period: 4, exp_rise: 4'b0000, exp_fall: 4'b1111};

    // Reset and 50 idle cycles with sw low.
    repeat (3) step('0, 1'b1, 1'b1);
    check("reset db_level", db_level, '0);
    pulses = 0;
    for (int k = 0; k < 50; k++) begin
      step('0, (k % 4) == 3, 1'b0);
      if ((rise_pulse | fall_pulse) != '0) pulses++;
    end
    check_int("idle pulses", pulses, 0);

    foreach (tbl[i]) run_entry(i);

    // Glitch back to the old level after two ticks restarts qualification.
    repeat (LAT) step(4'b0010, 1'b0, 1'b0);
    step(4'b0010, 1'b1, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0010, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    repeat (LAT) step(4'b0010, 1'b0, 1'b0);
    step(4'b0010, 1'b1, 1'b0);
    check("glitch no early 1", rise_pulse, '0);
    step(4'b0010, 1'b1, 1'b0);
    check("glitch no early 2", rise_pulse, '0);
    step(4'b0010, 1'b1, 1'b0);
    check("glitch accept", rise_pulse, 4'b0010);
    for (int k = 0; k < 20; k++) step('0, 1'b1, 1'b0);
    check("glitch released", db_level, '0);

    // Reset while the counter sits at 2, with a tick in the same cycle.
    repeat (LAT) step(4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b1, 1'b0);
    step(4'b0001, 1'b1, 1'b0);
    step(4'b0001, 1'b1, 1'b1);
    check("midreset level", db_level, '0);
    check("midreset rise", rise_pulse, '0);
    repeat (LAT) step(4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b1, 1'b0);
    step(4'b0001, 1'b1, 1'b0);
    check("postreset not yet", db_level, '0);
    step(4'b0001, 1'b1, 1'b0);
    check("postreset accept", db_level, 4'b0001);
    check("postreset rise", rise_pulse, 4'b0001);

    // Randomised run against the model.
    sw_r    = 4'b0001;
    tick_hi = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ((k % 256) == 0) tick_hi = ~tick_hi;
      for (int b = 0; b < int'(CH); b++)
        if ($urandom_range(7) == 0) sw_r[b] = ~sw_r[b];
      step(sw_r, tick_hi ? 1'b1 : ($urandom_range(2) == 0), $urandom_range(499) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
